csr_uart_fifo: RTL and testbench

// - Buffered character UART on the CSR bus. Parametrised TX and RX FIFOs, sticky error flags and an RX interrupt.
// - Same 3-stage CSR timing as the other CSR peripherals:
//   - D: register address decode.
//   - E: register rdata/valid and apply the write.
// - rdata/valid are ORed into the core's CSR read mux.
//

---
 rtl/csr_uart_fifo.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_csr_uart_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_uart_fifo.sv
// csr_uart_fifo: buffered character UART on the CSR bus.
//
// The TX and RX character FIFOs are parametrised. Overrun and framing
// errors are held in sticky flags. irq stays high while the RX FIFO holds
// data.
//
// CSR pipeline:
//   - addr is decoded in cycle n.
//   - valid/rdata are registered, and writes applied, at the end of cycle n+1.
//   - modify/wdata are presented in cycle n+1.
//
// Register map:
//   BASE_ADDR    status/data.
//                Read: [7:0] RX head, [8] rx_empty, [9] tx_full,
//                [10] overrun, [11] frame_err, [31:16] RX count.
//                Write 001 pushes a TX char.
//                Set 010: bit0 pops RX, bit1 clears overrun,
//                bit2 clears frame_err.
//   BASE_ADDR+1  divisor CSR. It only exists when CSR_UART_FIFO_DIV_EN is
//                defined; otherwise the bit period is fixed at
//                CLOCK_RATE/BAUD_RATE.
//
// Ports:
//   clk, rstn      clock and synchronous active-low reset
//   read           CSR read strobe (reads have no side effects, unused)
//   modify[2:0]    001 write, 010 set, 011 clear
//   wdata[31:0]    CSR write data
//   addr[11:0]     CSR address (decode stage)
//   rdata[31:0]    registered read data, 0 when not selected
//   valid          registered address hit
//   rx             asynchronous serial input
//   tx             registered serial output, idle high
//   irq            registered RX-not-empty
module csr_uart_fifo #(
    parameter logic [11:0] BASE_ADDR  = 12'hbc0,
    parameter int          CLOCK_RATE = 12_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          TX_DEPTH   = 4,
    parameter int          RX_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam logic [15:0] DIV_RST = 16'(CLOCK_RATE / BAUD_RATE);
    localparam logic [15:0] DIV_MIN = 16'd4;
    localparam logic [TX_DEPTH:0]   TX_CNT_ONE = (TX_DEPTH + 1)'(1'b1);
    localparam logic [RX_DEPTH:0]   RX_CNT_ONE = (RX_DEPTH + 1)'(1'b1);
    localparam logic [TX_DEPTH-1:0] TX_PTR_ONE = TX_DEPTH'(1'b1);
    localparam logic [RX_DEPTH-1:0] RX_PTR_ONE = RX_DEPTH'(1'b1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

    logic        sel_stat_r;
    logic        div_hit_s;
    logic [15:0] div_s;
    logic        tx_push_s, rx_pop_s, clr_ovr_s, clr_fe_s, set_op_s;
    logic        overrun_r, frame_err_r;
    logic        valid_r, irq_r, tx_r;
    logic [31:0] rdata_r, status_s;
    logic        unused_s;

    // Decode stage: register the status address hit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_stat_r <= 1'b0;
        end else begin
            sel_stat_r <= (addr == BASE_ADDR);
        end
    end

`ifdef CSR_UART_FIFO_DIV_EN
    localparam logic [11:0] DIV_ADDR = BASE_ADDR + 12'd1;
    logic        sel_div_r;
    logic [15:0] div_r, div_new_s;

    // Decode stage: register the divisor address hit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_div_r <= 1'b0;
        end else begin
            sel_div_r <= (addr == DIV_ADDR);
        end
    end

    // Bitwise update of the divisor, clamped so a bit is never shorter than 4 clocks.
    always_comb begin
        div_new_s = div_r;
        case (modify)
            3'b001:  div_new_s = wdata[15:0];
            3'b010:  div_new_s = div_r | wdata[15:0];
            3'b011:  div_new_s = div_r & ~wdata[15:0];
            default: div_new_s = div_r;
        endcase
        if (div_new_s < DIV_MIN) begin
            div_new_s = DIV_MIN;
        end else begin
            div_new_s = div_new_s;
        end
    end

    // Divisor register; running frames pick up a new value at their next bit boundary.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_r <= DIV_RST;
        end else if (sel_div_r) begin
            div_r <= div_new_s;
        end else begin
            div_r <= div_r;
        end
    end

    assign div_hit_s = sel_div_r;
    assign div_s     = div_r;
`else
    assign div_hit_s = 1'b0;
    assign div_s     = DIV_RST;
`endif

    assign unused_s  = ^{read, wdata[31:8]};
    assign set_op_s  = sel_stat_r && (modify == 3'b010);
    assign tx_push_s = sel_stat_r && (modify == 3'b001);
    assign rx_pop_s  = set_op_s && wdata[0];
    assign clr_ovr_s = set_op_s && wdata[1];
    assign clr_fe_s  = set_op_s && wdata[2];

    // ---------------- TX FIFO ----------------
    logic [7:0]          tx_mem_r [0:(2**TX_DEPTH)-1];
    logic [TX_DEPTH-1:0] tx_wptr_r, tx_rptr_r;
    logic [TX_DEPTH:0]   tx_count_r;
    logic                tx_empty_s, tx_full_s, tx_wr_s, tx_rd_s, tx_pop_s;

    assign tx_empty_s = (tx_count_r == {(TX_DEPTH + 1){1'b0}});
    assign tx_full_s  = tx_count_r[TX_DEPTH];
    assign tx_wr_s    = tx_push_s && !tx_full_s;
    assign tx_rd_s    = tx_pop_s && !tx_empty_s;

    // TX FIFO storage; contents need no reset because the count guards them.
    always_ff @(posedge clk) begin
        if (tx_wr_s) begin
            tx_mem_r[tx_wptr_r] <= wdata[7:0];
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wptr_r  <= {TX_DEPTH{1'b0}};
            tx_rptr_r  <= {TX_DEPTH{1'b0}};
            tx_count_r <= {(TX_DEPTH + 1){1'b0}};
        end else begin
            if (tx_wr_s) tx_wptr_r <= tx_wptr_r + TX_PTR_ONE;
            if (tx_rd_s) tx_rptr_r <= tx_rptr_r + TX_PTR_ONE;
            case ({tx_wr_s, tx_rd_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]          rx_mem_r [0:(2**RX_DEPTH)-1];
    logic [RX_DEPTH-1:0] rx_wptr_r, rx_rptr_r;
    logic [RX_DEPTH:0]   rx_count_r;
    logic                rx_empty_s, rx_full_s, rx_wr_s, rx_rd_s, rx_push_s;
    logic [7:0]          rx_shift_r, rx_char_s;

    assign rx_empty_s = (rx_count_r == {(RX_DEPTH + 1){1'b0}});
    assign rx_full_s  = rx_count_r[RX_DEPTH];
    assign rx_wr_s    = rx_push_s && !rx_full_s;
    assign rx_rd_s    = rx_pop_s && !rx_empty_s;
    assign rx_char_s  = rx_empty_s ? 8'h00 : rx_mem_r[rx_rptr_r];

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_wr_s) begin
            rx_mem_r[rx_wptr_r] <= rx_shift_r;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_wptr_r  <= {RX_DEPTH{1'b0}};
            rx_rptr_r  <= {RX_DEPTH{1'b0}};
            rx_count_r <= {(RX_DEPTH + 1){1'b0}};
        end else begin
            if (rx_wr_s) rx_wptr_r <= rx_wptr_r + RX_PTR_ONE;
            if (rx_rd_s) rx_rptr_r <= rx_rptr_r + RX_PTR_ONE;
            case ({rx_wr_s, rx_rd_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // ---------------- RX receiver ----------------
    logic        rx_meta_r, rx_sync_r;
    rx_state_t   rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s, rx_period_r, rx_period_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_s;
    logic        fe_set_s;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next state. Each bit period is latched when it starts, so a new DIV waits for a boundary.
    always_comb begin
        rx_state_s  = rx_state_r;
        rx_cnt_s    = rx_cnt_r;
        rx_period_s = rx_period_r;
        rx_bit_s    = rx_bit_r;
        rx_shift_s  = rx_shift_r;
        rx_push_s   = 1'b0;
        fe_set_s    = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_s  = RX_START;
                    rx_cnt_s    = 16'd0;
                    rx_period_s = {1'b0, div_s[15:1]};
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == rx_period_r - 16'd1) begin
                    rx_cnt_s    = 16'd0;
                    rx_period_s = div_s;
                    rx_bit_s    = 3'd0;
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (rx_sync_r) begin
                        rx_state_s = RX_IDLE;
                    end else begin
                        rx_state_s = RX_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == rx_period_r - 16'd1) begin
                    rx_cnt_s    = 16'd0;
                    rx_period_s = div_s;
                    rx_shift_s  = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == rx_period_r - 16'd1) begin
                    rx_cnt_s   = 16'd0;
                    rx_state_s = RX_IDLE;
                    if (rx_sync_r) begin
                        rx_push_s = 1'b1;
                    end else begin
                        fe_set_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // RX state register; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state_r  <= RX_IDLE;
            rx_cnt_r    <= 16'd0;
            rx_period_r <= DIV_RST;
            rx_bit_r    <= 3'd0;
            rx_shift_r  <= 8'h00;
        end else begin
            rx_state_r  <= rx_state_s;
            rx_cnt_r    <= rx_cnt_s;
            rx_period_r <= rx_period_s;
            rx_bit_r    <= rx_bit_s;
            rx_shift_r  <= rx_shift_s;
        end
    end

    // Sticky error flags; a same-cycle set beats the software clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (rx_push_s && rx_full_s) overrun_r <= 1'b1;
            else if (clr_ovr_s)         overrun_r <= 1'b0;
            else                        overrun_r <= overrun_r;
            if (fe_set_s)               frame_err_r <= 1'b1;
            else if (clr_fe_s)          frame_err_r <= 1'b0;
            else                        frame_err_r <= frame_err_r;
        end
    end

    // ---------------- TX transmitter ----------------
    tx_state_t   tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s, tx_period_r, tx_period_s;
    logic [3:0]  tx_bit_r, tx_bit_s;
    logic [8:0]  tx_shift_r, tx_shift_s;   // {stop, char}; the start bit goes straight to tx
    logic        tx_out_s, tx_load_s;

    // TX next state. The next char reloads on the stop bit's last edge, so frames stay contiguous.
    always_comb begin
        tx_state_s  = tx_state_r;
        tx_cnt_s    = tx_cnt_r;
        tx_period_s = tx_period_r;
        tx_bit_s    = tx_bit_r;
        tx_shift_s  = tx_shift_r;
        tx_out_s    = tx_r;
        tx_load_s   = 1'b0;
        tx_pop_s    = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_load_s = 1'b1;
                end else begin
                    tx_out_s = 1'b1;
                end
            end
            TX_SEND: begin
                if (tx_cnt_r == tx_period_r - 16'd1) begin
                    if (tx_bit_r == 4'd9) begin
                        if (!tx_empty_s) begin
                            tx_load_s = 1'b1;
                        end else begin
                            tx_state_s = TX_IDLE;
                            tx_out_s   = 1'b1;
                        end
                    end else begin
                        tx_cnt_s    = 16'd0;
                        tx_period_s = div_s;
                        tx_bit_s    = tx_bit_r + 4'd1;
                        tx_out_s    = tx_shift_r[0];
                        tx_shift_s  = {1'b1, tx_shift_r[8:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_out_s   = 1'b1;
            end
        endcase
        if (tx_load_s) begin
            tx_pop_s    = 1'b1;
            tx_state_s  = TX_SEND;
            tx_shift_s  = {1'b1, tx_mem_r[tx_rptr_r]};
            tx_out_s    = 1'b0;
            tx_cnt_s    = 16'd0;
            tx_bit_s    = 4'd0;
            tx_period_s = div_s;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // TX state register and registered serial output.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= 16'd0;
            tx_period_r <= DIV_RST;
            tx_bit_r    <= 4'd0;
            tx_shift_r  <= 9'h1ff;
            tx_r        <= 1'b1;
        end else begin
            tx_state_r  <= tx_state_s;
            tx_cnt_r    <= tx_cnt_s;
            tx_period_r <= tx_period_s;
            tx_bit_r    <= tx_bit_s;
            tx_shift_r  <= tx_shift_s;
            tx_r        <= tx_out_s;
        end
    end

    // ---------------- CSR read side ----------------
    assign status_s = {16'(rx_count_r), 4'h0, frame_err_r, overrun_r,
                       tx_full_s, rx_empty_s, rx_char_s};

    // Execute stage: register valid/rdata from pre-update state, plus irq.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
            irq_r   <= 1'b0;
        end else begin
            valid_r <= sel_stat_r || div_hit_s;
            if (sel_stat_r)     rdata_r <= status_s;
            else if (div_hit_s) rdata_r <= {16'h0000, div_s};
            else                rdata_r <= 32'h0000_0000;
            irq_r   <= !rx_empty_s;
        end
    end

    assign rdata = rdata_r;
    assign valid = valid_r;
    assign tx    = tx_r;
    assign irq   = irq_r;

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed testbench for csr_uart_fifo. It runs with DIV=16 and 4-entry FIFOs.
module tb_csr_uart_fifo;

    localparam logic [11:0] BASE  = 12'hbc0;
    localparam logic [11:0] DIVA  = 12'hbc1;
    localparam logic [11:0] IDLEA = 12'h000;
    localparam logic [31:0] POP_EXP [3] = '{32'h0003_0402, 32'h0002_0403, 32'h0001_0404};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'b000;
    logic [31:0] wdata = 32'h0;
    logic [11:0] addr = 12'h000;
    logic [31:0] rdata;
    logic        valid;
    logic        rx = 1'b1;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_uart_fifo #(
        .BASE_ADDR (12'hbc0),
        .CLOCK_RATE(16),
        .BAUD_RATE (1),
        .TX_DEPTH  (2),
        .RX_DEPTH  (2)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .read  (read),
        .modify(modify),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .valid (valid),
        .rx    (rx),
        .tx    (tx),
        .irq   (irq)
    );

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic v);
        @(posedge clk); #1 addr = a; read = 1'b1;
        @(posedge clk); #1 addr = IDLEA; read = 1'b0;
        @(posedge clk); #1 d = rdata; v = valid;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [2:0] m, input logic [31:0] w);
        @(posedge clk); #1 addr = a;
        @(posedge clk); #1 addr = IDLEA; modify = m; wdata = w;
        @(posedge clk); #1 modify = 3'b000; wdata = 32'h0;
    endtask

    task automatic send_rx(input logic [7:0] c, input logic stop);
        logic [9:0] f;
        f = {stop, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_low(input int limit, output bit ok);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (tx === 1'b0);
    endtask

    // Called on the cycle the start bit appears; samples each bit at its centre.
    task automatic capture_frame(output logic [9:0] f);
        repeat (8) @(posedge clk);
        #1 f[0] = tx;
        for (int i = 1; i < 10; i++) begin
            repeat (16) @(posedge clk);
            #1 f[i] = tx;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
        @(posedge clk); #1 addr = BASE;
        @(posedge clk); #1 addr = IDLEA;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL read_valid_early: got %b expected 0", valid); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b expected 1", valid); end
        checks++; if (rdata !== 32'h0000_0100) begin errors++; $display("FAIL reset_status: got %h expected 00000100", rdata); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [9:0] f;
        @(posedge clk); #1 addr = BASE;
        @(posedge clk); #1 modify = 3'b001; wdata = 32'h55;
        @(posedge clk); #1 addr = IDLEA; wdata = 32'hA3;
        @(posedge clk); #1 modify = 3'b000; wdata = 32'h0;
        wait_tx_low(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_start: got no start bit expected one within 20 cycles"); end
        capture_frame(f);
        checks++; if (f !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL tx_frame1: got %b expected %b", f, {1'b1, 8'h55, 1'b0}); end
        repeat (7) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_stop_end: got %b expected 1", tx); end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_no_gap: got %b expected 0", tx); end
        capture_frame(f);
        checks++; if (f !== {1'b1, 8'hA3, 1'b0}) begin errors++; $display("FAIL tx_frame2: got %b expected %b", f, {1'b1, 8'hA3, 1'b0}); end
        repeat (18) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b expected 1", tx); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic v;
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0004_0401) begin errors++; $display("FAIL rx_full_status: got %h expected 00040401", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b expected 1", irq); end
        for (int i = 0; i < 3; i++) begin
            csr_write(BASE, 3'b010, 32'h1);
            csr_read(BASE, d, v);
            checks++; if (d !== POP_EXP[i]) begin errors++; $display("FAIL rx_pop%0d: got %h expected %h", i, d, POP_EXP[i]); end
        end
        csr_write(BASE, 3'b010, 32'h1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b expected 1", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0500) begin errors++; $display("FAIL rx_empty_ovr: got %h expected 00000500", d); end
        csr_write(BASE, 3'b010, 32'h2);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL ovr_clear: got %h expected 00000100", d); end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        logic v;
        send_rx(8'h7E, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0900) begin errors++; $display("FAIL frame_err: got %h expected 00000900", d); end
        csr_write(BASE, 3'b010, 32'h4);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL fe_clear: got %h expected 00000100", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic v;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL glitch: got %h expected 00000100", d); end
        send_rx(8'h3C, 1'b1);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0001_003C) begin errors++; $display("FAIL after_glitch: got %h expected 0001003c", d); end
        csr_write(BASE, 3'b010, 32'h1);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL glitch_pop: got %h expected 00000100", d); end
    endtask

    task automatic test_divisor();
        logic [31:0] d;
        logic v;
        bit ok;
`ifdef CSR_UART_FIFO_DIV_EN
        csr_write(DIVA, 3'b001, 32'hABCD_0008);
        csr_read(DIVA, d, v);
        checks++; if (v !== 1'b1 || d !== 32'h0000_0008) begin errors++; $display("FAIL div_write: got %h/%b expected 00000008/1", d, v); end
        csr_write(BASE, 3'b001, 32'h0F);
        wait_tx_low(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL div_tx_start: got no start bit expected one"); end
        repeat (7) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL div_start_len: got %b expected 0", tx); end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL div_bit0: got %b expected 1", tx); end
        repeat (100) @(posedge clk);
        #1;
        csr_write(DIVA, 3'b001, 32'h1);
        csr_read(DIVA, d, v);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL div_clamp: got %h expected 00000004", d); end
        csr_write(DIVA, 3'b010, 32'h10);
        csr_read(DIVA, d, v);
        checks++; if (d !== 32'h0000_0014) begin errors++; $display("FAIL div_set: got %h expected 00000014", d); end
        csr_write(DIVA, 3'b011, 32'h14);
        csr_read(DIVA, d, v);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL div_clear: got %h expected 00000004", d); end
        csr_write(DIVA, 3'b001, 32'h10);
`else
        csr_read(DIVA, d, v);
        checks++; if (v !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL div_absent: got %h/%b expected 00000000/0", d, v); end
        csr_write(DIVA, 3'b001, 32'h8);
        csr_write(BASE, 3'b001, 32'h0F);
        wait_tx_low(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fixed_tx_start: got no start bit expected one"); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL fixed_start_len: got %b expected 0", tx); end
        repeat (8) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fixed_bit0: got %b expected 1", tx); end
        repeat (160) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        logic v;
        int lows;
        for (int i = 0; i < 6; i++) csr_write(BASE, 3'b001, 32'h00);
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0300) begin errors++; $display("FAIL tx_full: got %h expected 00000300", d); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_frame: got %b expected 0", tx); end
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_mid: got %b expected 1", tx); end
        rstn = 1'b1;
        csr_read(BASE, d, v);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL reset_fifo: got %h expected 00000100", d); end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL tx_quiet: got %0d low cycles expected 0", lows); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rx_overrun();
        test_frame_err();
        test_glitch();
        test_divisor();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
